control_seq: RTL and testbench
==============================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter STATE_W, default 8, width of the state output; SHALL be at least 4.
REQ-002 Parameter REG_W, default 3, width of the register-select operand fields.
REQ-003 Parameter TMO_CYC, default 255, GPIO handshake timeout in cycles; SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 run  in  1  high = sequencing enabled; low = hold in FETCH_PC.
REQ-007 ir_class  in  3  instruction class from IR; valid from DECODE onward.
REQ-008 ir_op1  in  REG_W  destination/source register field.
REQ-009 ir_op2  in  REG_W  second register field, or condition code for jumps (low 3 bits).
REQ-010 flag_zero, flag_carry, flag_neg  in  1 each  ALU flags.
REQ-011 gpio_ready  in  1  GPIO peripheral handshake acknowledge.
REQ-012 state  out  STATE_W  current state code, zero-extended.
REQ-013 rf_sel  out  REG_W  register-file address: ir_op2 in MOV_REG and ROUT_STORE, else ir_op1.
REQ-014 ctrl  out  14  control strobes: [0]ii [1]ci [2]co [3]cs [4]rfi [5]rfo [6]eo [7]ee [8]mi [9]ro [10]ri [11]gi [12]go [13]halt.
REQ-015 err_tmo  out  1  sticky GPIO-timeout flag.

Function
REQ-016 State codes: FETCH_PC=0, FETCH_INST=1, DECODE=2, ALU_EXEC=3, ALU_OUT=4, MOV_REG=5, FETCH_ARG=6, SET_REG=7, JUMP=8, GPIO_WAIT=9, RIN_STORE=10, ROUT_STORE=11, HALT=12; any other code SHALL go to FETCH_PC next cycle.
REQ-017 FETCH_PC -> FETCH_INST when run=1, else stay; FETCH_INST -> DECODE.
REQ-018 DECODE by ir_class: 0 NOP -> FETCH_PC; 1 ALU -> ALU_EXEC -> ALU_OUT -> FETCH_PC; 2 MOV -> MOV_REG -> FETCH_PC; 3 LDI -> FETCH_ARG -> SET_REG -> FETCH_PC; 4 JMP -> FETCH_ARG -> JUMP -> FETCH_PC; 5 GIN and 6 GOUT -> GPIO_WAIT; 7 HALT -> HALT.
REQ-019 GPIO_WAIT: gpio_ready=1 -> RIN_STORE for class 5, ROUT_STORE for class 6, then FETCH_PC; the timeout counter SHALL clear on GPIO_WAIT entry and increment each cycle; when it reaches TMO_CYC with gpio_ready=0 -> FETCH_PC and set err_tmo.
REQ-020 gpio_ready=1 in the same cycle the count reaches TMO_CYC SHALL win: no timeout, err_tmo unchanged.
REQ-021 HALT is terminal; only reset leaves it; run is ignored in HALT.
REQ-022 run is sampled only in FETCH_PC; deasserting run mid-instruction SHALL not abort it.
REQ-023 Strobes are decoded from the state register:
- FETCH_PC: co, mi, ci.
- FETCH_INST: ro, ii.
- ALU_EXEC: ee.
- ALU_OUT: eo, rfi.
- MOV_REG: rfo, rfi.
- FETCH_ARG: co, mi, ci.
- SET_REG: ro, rfi.
- JUMP: ro, ci, cs, all three only if the jump is taken.
- RIN_STORE: gi, rfi.
- ROUT_STORE: rfo, go.
- HALT: halt.
- All other bits 0.
REQ-024 Jump is taken when ir_op2[2:0] selects a condition that holds: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 never. Flags are evaluated combinationally during JUMP.
REQ-025 An untaken JUMP SHALL assert no strobes; the PC has already skipped the address byte in FETCH_ARG.
REQ-026 At most one of rfi/rfo-driving sources, and at most one of ro/eo/co/rfo/gi bus drivers except MOV_REG (rfo+rfi), SHALL be asserted per cycle.

Reset
REQ-027 While reset=1: state=FETCH_PC, ctrl=0 except co|mi|ci gated off, err_tmo=0, timeout counter=0; all asynchronous.
REQ-028 After reset deasserts, the first FETCH_PC strobes SHALL appear in the cycle run=1 is seen.
REQ-029 Reset mid-instruction, including in GPIO_WAIT or HALT, SHALL abandon it immediately with no further strobes.

Verification
REQ-030 run=1, ir_class=1 -> states 0,1,2,3,4,0 in six cycles; ee in state 3; eo+rfi in state 4.
REQ-031 ir_class=4, ir_op2=1, flag_zero=0 -> JUMP with ctrl=0; repeat with flag_zero=1 -> ro+ci+cs in JUMP.
REQ-032 ir_class=5, TMO_CYC=4, gpio_ready held 0 -> return to FETCH_PC, err_tmo=1 and held until reset.
REQ-033 ir_class=6, gpio_ready=1 on the 3rd GPIO_WAIT cycle -> ROUT_STORE with rfo+go, rf_sel=ir_op2, err_tmo=0.
REQ-034 ir_class=7 -> HALT with halt=1 held for 100 cycles regardless of run; reset -> state=0, ctrl=0.
REQ-035 run=0 after reset -> state stays 0 with all strobes 0; run pulsed low during ALU_EXEC -> instruction still completes.

Source files
------------

// File: rtl/control_seq.sv
// control_seq -- microcoded instruction sequencer.
// Walks the fetch / decode / execute states for an 8-class instruction set,
// decodes one-cycle control strobes from the current state, and supervises
// the GPIO handshake with a bounded wait and a sticky timeout flag.

module control_seq #(
    parameter int STATE_W = 8,   // width of the exported state code, >= 4
    parameter int REG_W   = 3,   // width of the register-select fields
    parameter int TMO_CYC = 255  // longest GPIO wait in cycles, >= 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [2:0]         ir_class,
    input  logic [REG_W-1:0]   ir_op1,
    input  logic [REG_W-1:0]   ir_op2,
    input  logic               flag_zero,
    input  logic               flag_carry,
    input  logic               flag_neg,
    input  logic               gpio_ready,
    output logic [STATE_W-1:0] state,
    output logic [REG_W-1:0]   rf_sel,
    output logic [13:0]        ctrl,
    output logic               err_tmo
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        FETCH_PC   = 4'd0,
        FETCH_INST = 4'd1,
        DECODE     = 4'd2,
        ALU_EXEC   = 4'd3,
        ALU_OUT    = 4'd4,
        MOV_REG    = 4'd5,
        FETCH_ARG  = 4'd6,
        SET_REG    = 4'd7,
        JUMP       = 4'd8,
        GPIO_WAIT  = 4'd9,
        RIN_STORE  = 4'd10,
        ROUT_STORE = 4'd11,
        HALT       = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_MOV  = 3'd2,
        CLS_LDI  = 3'd3,
        CLS_JMP  = 3'd4,
        CLS_GIN  = 3'd5,
        CLS_GOUT = 3'd6,
        CLS_HALT = 3'd7
    } iclass_t;

    // Jump condition codes carried in the low three bits of ir_op2.
    typedef enum logic [2:0] {
        CC_ALWAYS = 3'd0,
        CC_Z      = 3'd1,
        CC_NZ     = 3'd2,
        CC_C      = 3'd3,
        CC_NC     = 3'd4,
        CC_N      = 3'd5,
        CC_NN     = 3'd6,
        CC_NEVER  = 3'd7
    } cond_t;

    // Bit positions inside ctrl.
    localparam int C_II   = 0;   // instruction register in
    localparam int C_CI   = 1;   // program counter increment
    localparam int C_CO   = 2;   // program counter out (bus driver)
    localparam int C_CS   = 3;   // program counter set (jump load)
    localparam int C_RFI  = 4;   // register file in
    localparam int C_RFO  = 5;   // register file out (bus driver)
    localparam int C_EO   = 6;   // ALU result out (bus driver)
    localparam int C_EE   = 7;   // ALU execute enable
    localparam int C_MI   = 8;   // memory address in
    localparam int C_RO   = 9;   // memory read out (bus driver)
    localparam int C_RI   = 10;  // memory write in (unused by this sequence)
    localparam int C_GI   = 11;  // GPIO in (bus driver)
    localparam int C_GO   = 12;  // GPIO out
    localparam int C_HALT = 13;  // processor halted

    // The wait counter only ever holds 0 .. TMO_CYC-1.
    localparam int               TMO_W    = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err_tmo;

    logic [2:0]       w_cond;
    logic             w_jump_taken;
    logic             w_tmo_hit;
    logic             w_timeout;

    // ------------------------------------------------------------------
    // Jump condition evaluation (flags are live during JUMP)
    // ------------------------------------------------------------------
    assign w_cond = 3'(ir_op2);

    // Resolve whether the jump selected by the condition code is taken.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_jump_taken = 1'b0;
        case (cond_t'(w_cond))
            CC_ALWAYS: w_jump_taken = 1'b1;
            CC_Z:      w_jump_taken = flag_zero;
            CC_NZ:     w_jump_taken = !flag_zero;
            CC_C:      w_jump_taken = flag_carry;
            CC_NC:     w_jump_taken = !flag_carry;
            CC_N:      w_jump_taken = flag_neg;
            CC_NN:     w_jump_taken = !flag_neg;
            CC_NEVER:  w_jump_taken = 1'b0;
            default:   w_jump_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // GPIO handshake supervision
    // ------------------------------------------------------------------
    // The last permitted wait cycle is the one where the counter reads
    // TMO_CYC-1, so GPIO_WAIT lasts at most TMO_CYC cycles. A ready seen in
    // that same cycle still completes the transfer.
    assign w_tmo_hit = (r_state == GPIO_WAIT) && (r_tmo_cnt == TMO_LAST);
    assign w_timeout = w_tmo_hit && !gpio_ready;

    // Count cycles spent in GPIO_WAIT; zero everywhere else so each entry starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == GPIO_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Sticky timeout flag: set by an expired handshake, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_tmo <= 1'b0;
        end else if (w_timeout) begin
            r_err_tmo <= 1'b1;
        end
    end

    assign err_tmo = r_err_tmo;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    // State register; reset forces FETCH_PC asynchronously, abandoning any instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_PC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; run is only consulted in FETCH_PC.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH_PC: begin
                if (run) begin
                    w_next_state = FETCH_INST;
                end
            end
            FETCH_INST: w_next_state = DECODE;
            DECODE: begin
                case (iclass_t'(ir_class))
                    CLS_NOP:  w_next_state = FETCH_PC;
                    CLS_ALU:  w_next_state = ALU_EXEC;
                    CLS_MOV:  w_next_state = MOV_REG;
                    CLS_LDI:  w_next_state = FETCH_ARG;
                    CLS_JMP:  w_next_state = FETCH_ARG;
                    CLS_GIN:  w_next_state = GPIO_WAIT;
                    CLS_GOUT: w_next_state = GPIO_WAIT;
                    CLS_HALT: w_next_state = HALT;
                    default:  w_next_state = FETCH_PC;
                endcase
            end
            ALU_EXEC:  w_next_state = ALU_OUT;
            FETCH_ARG: begin
                // Only LDI and JMP reach here; the argument byte feeds one or the other.
                if (ir_class == CLS_JMP) begin
                    w_next_state = JUMP;
                end else begin
                    w_next_state = SET_REG;
                end
            end
            GPIO_WAIT: begin
                if (gpio_ready) begin
                    if (ir_class == CLS_GIN) begin
                        w_next_state = RIN_STORE;
                    end else begin
                        w_next_state = ROUT_STORE;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = FETCH_PC;
                end
            end
            ALU_OUT,
            MOV_REG,
            SET_REG,
            JUMP,
            RIN_STORE,
            ROUT_STORE: w_next_state = FETCH_PC;
            HALT:       w_next_state = HALT;
            default:    w_next_state = FETCH_PC;
        endcase
    end

    // Output decode: strobes from the state register, register-file address select.
    always_comb begin
        ctrl   = '0;
        rf_sel = ir_op1;
        case (r_state)
            MOV_REG, ROUT_STORE: rf_sel = ir_op2;
            default:             rf_sel = ir_op1;
        endcase
        // While reset is held the state already reads FETCH_PC; keep its
        // strobes off so nothing fires until reset is released.
        if (!reset) begin
            case (r_state)
                FETCH_PC: begin
                    if (run) begin
                        ctrl[C_CO] = 1'b1;
                        ctrl[C_MI] = 1'b1;
                        ctrl[C_CI] = 1'b1;
                    end
                end
                FETCH_INST: begin
                    ctrl[C_RO] = 1'b1;
                    ctrl[C_II] = 1'b1;
                end
                ALU_EXEC: ctrl[C_EE] = 1'b1;
                ALU_OUT: begin
                    ctrl[C_EO]  = 1'b1;
                    ctrl[C_RFI] = 1'b1;
                end
                MOV_REG: begin
                    ctrl[C_RFO] = 1'b1;
                    ctrl[C_RFI] = 1'b1;
                end
                FETCH_ARG: begin
                    ctrl[C_CO] = 1'b1;
                    ctrl[C_MI] = 1'b1;
                    ctrl[C_CI] = 1'b1;
                end
                SET_REG: begin
                    ctrl[C_RO]  = 1'b1;
                    ctrl[C_RFI] = 1'b1;
                end
                JUMP: begin
                    // Untaken: silent, the PC already stepped past the address byte.
                    if (w_jump_taken) begin
                        ctrl[C_RO] = 1'b1;
                        ctrl[C_CI] = 1'b1;
                        ctrl[C_CS] = 1'b1;
                    end
                end
                RIN_STORE: begin
                    ctrl[C_GI]  = 1'b1;
                    ctrl[C_RFI] = 1'b1;
                end
                ROUT_STORE: begin
                    ctrl[C_RFO] = 1'b1;
                    ctrl[C_GO]  = 1'b1;
                end
                HALT:    ctrl[C_HALT] = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    assign state = STATE_W'(r_state);

    // ------------------------------------------------------------------
    // Structural invariants of the strobe decode
    // ------------------------------------------------------------------
    // At most one bus driver per cycle.
    a_one_bus_driver : assert property (@(posedge clk) disable iff (reset)
        $onehot0({ctrl[C_RO], ctrl[C_EO], ctrl[C_CO], ctrl[C_RFO], ctrl[C_GI]}));

    // Register file reads and writes together only for a register move.
    a_rf_direction : assert property (@(posedge clk) disable iff (reset)
        !(ctrl[C_RFI] && ctrl[C_RFO]) || (r_state == MOV_REG));

    // The memory-write strobe is never part of this sequence.
    a_no_ri : assert property (@(posedge clk) disable iff (reset) !ctrl[C_RI]);

    // Only defined state codes are ever reached.
    a_legal_state : assert property (@(posedge clk) disable iff (reset)
        r_state <= HALT);

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq -- directed bench for control_seq.
// Each instruction is expanded into the list of states the specification
// prescribes for its class; the bench steps through that list one cycle at a
// time, and a single compare process checks state, strobes, rf_sel and
// err_tmo on every falling edge. A few literal strobe words pin the model.

module tb_control_seq;

    localparam int STATE_W = 8;
    localparam int REG_W   = 3;
    localparam int TMO_CYC = 4;

    // State codes as listed in the specification.
    localparam int ST_FPC  = 0;
    localparam int ST_FIN  = 1;
    localparam int ST_DEC  = 2;
    localparam int ST_AEX  = 3;
    localparam int ST_AOUT = 4;
    localparam int ST_MOV  = 5;
    localparam int ST_FARG = 6;
    localparam int ST_SET  = 7;
    localparam int ST_JMP  = 8;
    localparam int ST_GW   = 9;
    localparam int ST_RIN  = 10;
    localparam int ST_ROUT = 11;
    localparam int ST_HALT = 12;

    // ctrl bit positions.
    localparam int B_II = 0, B_CI = 1, B_CO = 2, B_CS = 3, B_RFI = 4, B_RFO = 5,
                   B_EO = 6, B_EE = 7, B_MI = 8, B_RO = 9, B_GI = 11,
                   B_GO = 12, B_HALT = 13;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic [2:0]         ir_class;
    logic [REG_W-1:0]   ir_op1;
    logic [REG_W-1:0]   ir_op2;
    logic               flag_zero;
    logic               flag_carry;
    logic               flag_neg;
    logic               gpio_ready;
    logic [STATE_W-1:0] state;
    logic [REG_W-1:0]   rf_sel;
    logic [13:0]        ctrl;
    logic               err_tmo;

    int total = 0;
    int bad   = 0;

    // Expected values for the current cycle.
    bit               exp_valid = 1'b0;
    int               exp_state;
    logic [13:0]      exp_ctrl;
    logic [REG_W-1:0] exp_rf;
    bit               exp_err;
    bit               model_err = 1'b0;

    control_seq #(
        .STATE_W (STATE_W),
        .REG_W   (REG_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ir_class   (ir_class),
        .ir_op1     (ir_op1),
        .ir_op2     (ir_op2),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_neg   (flag_neg),
        .gpio_ready (gpio_ready),
        .state      (state),
        .rf_sel     (rf_sel),
        .ctrl       (ctrl),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit jump_taken(input int cond, input bit z, input bit c, input bit n);
        case (cond)
            0:       return 1'b1;
            1:       return z;
            2:       return !z;
            3:       return c;
            4:       return !c;
            5:       return n;
            6:       return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Strobe table straight from the state/strobe list.
    function automatic logic [13:0] strobes(input int st, input bit run_v, input bit taken);
        logic [13:0] s;
        s = '0;
        case (st)
            ST_FPC:  if (run_v) begin s[B_CO] = 1'b1; s[B_MI] = 1'b1; s[B_CI] = 1'b1; end
            ST_FIN:  begin s[B_RO] = 1'b1; s[B_II] = 1'b1; end
            ST_AEX:  s[B_EE] = 1'b1;
            ST_AOUT: begin s[B_EO] = 1'b1; s[B_RFI] = 1'b1; end
            ST_MOV:  begin s[B_RFO] = 1'b1; s[B_RFI] = 1'b1; end
            ST_FARG: begin s[B_CO] = 1'b1; s[B_MI] = 1'b1; s[B_CI] = 1'b1; end
            ST_SET:  begin s[B_RO] = 1'b1; s[B_RFI] = 1'b1; end
            ST_JMP:  if (taken) begin s[B_RO] = 1'b1; s[B_CI] = 1'b1; s[B_CS] = 1'b1; end
            ST_RIN:  begin s[B_GI] = 1'b1; s[B_RFI] = 1'b1; end
            ST_ROUT: begin s[B_RFO] = 1'b1; s[B_GO] = 1'b1; end
            ST_HALT: s[B_HALT] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Compare process: every falling edge while an expectation is armed.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("state",   32'(state),   32'(exp_state));
            check("ctrl",    32'(ctrl),    32'(exp_ctrl));
            check("rf_sel",  32'(rf_sel),  32'(exp_rf));
            check("err_tmo", 32'(err_tmo), 32'(exp_err));
        end
    end

    // One cycle: drive inputs just after the rising edge, arm expectations,
    // optionally pin ctrl to a hand-computed word, end just after the next edge.
    task automatic step(input int st, input bit run_v, input bit gpio_v,
                        input bit lit_on = 1'b0, input logic [13:0] lit = 14'h0);
        run        = run_v;
        gpio_ready = gpio_v;
        exp_state  = st;
        exp_ctrl   = strobes(st, run_v,
                             jump_taken(int'(ir_op2[2:0]), flag_zero, flag_carry, flag_neg));
        exp_rf     = (st == ST_MOV || st == ST_ROUT) ? ir_op2 : ir_op1;
        exp_err    = model_err;
        exp_valid  = 1'b1;
        @(negedge clk);
        #1;
        if (lit_on) check("lit_ctrl", 32'(ctrl), 32'(lit));
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its state path and step through it.
    // gpio_k: GPIO_WAIT cycle (1-based) in which gpio_ready is raised, 0 = never.
    // run_low_st: state in which run is dropped (-1 = none).
    // abort_after: stop after this many cycles (0 = run to completion).
    task automatic exec(input logic [2:0] cls, input logic [REG_W-1:0] op1,
                        input logic [REG_W-1:0] op2, input bit z, input bit c, input bit n,
                        input int gpio_k, input int run_low_st, input int pin_st,
                        input logic [13:0] pin_ctrl, input int abort_after, input int halt_cycles);
        int  path[$];
        bit  tmo;
        int  waits;
        int  w;
        bit  run_v;
        bit  gpio_v;
        tmo = 1'b0;
        w   = 0;
        ir_class = cls; ir_op1 = op1; ir_op2 = op2;
        flag_zero = z; flag_carry = c; flag_neg = n;
        path = {ST_FPC, ST_FIN, ST_DEC};
        case (int'(cls))
            1: begin path.push_back(ST_AEX); path.push_back(ST_AOUT); end
            2: path.push_back(ST_MOV);
            3: begin path.push_back(ST_FARG); path.push_back(ST_SET); end
            4: begin path.push_back(ST_FARG); path.push_back(ST_JMP); end
            5, 6: begin
                waits = (gpio_k >= 1 && gpio_k <= TMO_CYC) ? gpio_k : TMO_CYC;
                repeat (waits) path.push_back(ST_GW);
                if (gpio_k >= 1 && gpio_k <= TMO_CYC)
                    path.push_back(int'(cls) == 5 ? ST_RIN : ST_ROUT);
                else
                    tmo = 1'b1;
            end
            7: repeat (halt_cycles) path.push_back(ST_HALT);
            default: ;
        endcase
        for (int i = 0; i < path.size(); i++) begin
            if (abort_after > 0 && i == abort_after) return;
            gpio_v = 1'b0;
            if (path[i] == ST_GW) begin
                w++;
                gpio_v = (w == gpio_k);
            end
            if (i == 0)                    run_v = 1'b1;
            else if (path[i] == ST_HALT)   run_v = 1'($urandom_range(0, 1));
            else                           run_v = (path[i] != run_low_st);
            step(path[i], run_v, gpio_v, path[i] == pin_st, pin_ctrl);
        end
        if (tmo) model_err = 1'b1;
    endtask

    // Assert reset mid-cycle, check the cleared outputs, release after one edge.
    task automatic do_reset();
        exp_valid = 1'b0;
        run       = 1'b1;
        reset     = 1'b1;
        #1;
        check("rst_state", 32'(state),   32'(0));
        check("rst_ctrl",  32'(ctrl),    32'(0));
        check("rst_err",   32'(err_tmo), 32'(0));
        model_err = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_ctrl", 32'(ctrl), 32'(0));
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; gpio_ready = 1'b0;
        ir_class = '0; ir_op1 = '0; ir_op2 = '0;
        flag_zero = 1'b0; flag_carry = 1'b0; flag_neg = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle with run low: no movement, no strobes.
        repeat (3) step(ST_FPC, 1'b0, 1'b0, 1'b1, 14'h0000);

        // ALU with run dropped during ALU_EXEC; ee pinned, then eo+rfi pinned.
        exec(3'd1, 3'd2, 3'd5, 0, 0, 0, 0, ST_AEX,  ST_AEX,  14'h0080, 0, 0);
        exec(3'd1, 3'd6, 3'd1, 0, 0, 0, 0, -1,      ST_AOUT, 14'h0050, 0, 0);
        // NOP with the fetch strobes pinned; MOV with rf_sel from op2; LDI.
        exec(3'd0, 3'd3, 3'd4, 0, 0, 0, 0, -1,      ST_FPC,  14'h0106, 0, 0);
        exec(3'd2, 3'd1, 3'd6, 0, 0, 0, 0, -1,      ST_MOV,  14'h0030, 0, 0);
        exec(3'd3, 3'd7, 3'd2, 0, 0, 0, 0, -1,      ST_SET,  14'h0210, 0, 0);

        // Jumps: JZ untaken then taken, then the remaining condition codes.
        exec(3'd4, 3'd0, 3'd1, 0, 0, 0, 0, -1, ST_JMP, 14'h0000, 0, 0);
        exec(3'd4, 3'd0, 3'd1, 1, 0, 0, 0, -1, ST_JMP, 14'h020A, 0, 0);
        exec(3'd4, 3'd0, 3'd0, 0, 0, 0, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd2, 1, 0, 0, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd3, 0, 1, 0, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd4, 0, 1, 0, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd5, 0, 0, 1, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd6, 0, 0, 1, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd4, 3'd0, 3'd7, 1, 1, 1, 0, -1, -1, 14'h0, 0, 0);

        // GPIO: GIN ready at once; GOUT ready on the 3rd wait cycle;
        // GIN ready exactly on the last allowed cycle (ready wins over timeout).
        exec(3'd5, 3'd4, 3'd1, 0, 0, 0, 1, -1, ST_RIN,  14'h0810, 0, 0);
        exec(3'd6, 3'd2, 3'd5, 0, 0, 0, 3, -1, ST_ROUT, 14'h1020, 0, 0);
        exec(3'd5, 3'd1, 3'd3, 0, 0, 0, TMO_CYC, -1, -1, 14'h0, 0, 0);

        // GIN never acknowledged: timeout, then err_tmo stays set.
        exec(3'd5, 3'd3, 3'd0, 0, 0, 0, 0, -1, -1, 14'h0, 0, 0);
        check("err_after_tmo", 32'(err_tmo), 32'(1));
        exec(3'd0, 3'd0, 3'd0, 0, 0, 0, 0, -1, -1, 14'h0, 0, 0);
        exec(3'd1, 3'd5, 3'd2, 0, 0, 0, 0, -1, -1, 14'h0, 0, 0);

        // Reset while in GPIO_WAIT clears everything including err_tmo.
        exec(3'd5, 3'd3, 3'd0, 0, 0, 0, 0, -1, -1, 14'h0, 5, 0);
        do_reset();
        step(ST_FPC, 1'b0, 1'b0);

        // HALT for 100 cycles with run toggling, then reset leaves it.
        exec(3'd7, 3'd0, 3'd0, 0, 0, 0, 0, -1, ST_HALT, 14'h2000, 0, 100);
        do_reset();
        repeat (2) step(ST_FPC, 1'b0, 1'b0);
        exec(3'd1, 3'd2, 3'd3, 0, 0, 0, 0, -1, -1, 14'h0, 0, 0);
        exp_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
